// File: rtl/dmem_lsu.sv
// Load/store unit: byte/half/word accesses onto a word-addressed memory, with read-modify-write for sub-word stores.
// Build option: define DMEM_LSU_ALIGN_CHECK_EN to flag misaligned/reserved requests instead of truncating them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module dmem_lsu #(
    parameter int W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_read_en,
    output logic [W-1:0] mem_read_addr,
    input  logic [W-1:0] mem_read_data,
    output logic         mem_write_en,
    output logic [W-1:0] mem_write_addr,
    output logic [W-1:0] mem_write_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_err_q, resp_err_d;
    logic [W-1:0] resp_rdata_q, resp_rdata_d;
    logic [W-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;

    logic         accept;
    logic         req_err;
    logic [1:0]   size_eff;
    logic [1:0]   lane_off;
    logic [W-1:0] addr_aligned;
    logic [W-1:0] lane_word;
    logic [W-1:0] load_data;
    logic [W-1:0] merged;
    logic         rd_en, wr_en;

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid & req_ready;
    assign addr_aligned = {req_addr[W-1:2], 2'b00};

    // Decode the effective size and lane; without the check, bad requests collapse onto a natural boundary.
    always_comb begin
        size_eff = req_size;
        req_err  = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        req_err = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == 2'b11) size_eff = 2'b10;
`endif
        lane_off = req_addr[1:0];
        case (size_eff)
            2'b01:   lane_off[0] = 1'b0;
            2'b10:   lane_off    = 2'b00;
            default: lane_off    = req_addr[1:0];
        endcase
    end

    always_comb begin
        lane_word = mem_read_data >> {lane_off, 3'b000};
        case (size_eff)
            2'b00:   load_data = {{(W-8){lane_word[7] & req_signed}}, lane_word[7:0]};
            2'b01:   load_data = {{(W-16){lane_word[15] & req_signed}}, lane_word[15:0]};
            default: load_data = mem_read_data;
        endcase
        merged = mem_read_data;
        if (size_eff == 2'b00)
            merged[{lane_off, 3'b000} +: 8] = req_wdata[7:0];
        else if (size_eff == 2'b01)
            merged[{lane_off, 3'b000} +: 16] = req_wdata[15:0];
    end

    always_comb begin
        state_d        = state_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        rd_en          = 1'b0;
        wr_en          = 1'b0;
        mem_write_addr = addr_aligned;
        mem_write_data = req_wdata;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_we) begin
                        rd_en        = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = load_data;
                    end else if (size_eff[1]) begin
                        wr_en        = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = '0;
                    end else begin
                        rd_en     = 1'b1;
                        wr_addr_d = addr_aligned;
                        wr_data_d = merged;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_en          = 1'b1;
                mem_write_addr = wr_addr_q;
                mem_write_data = wr_data_q;
                resp_valid_d   = 1'b1;
                resp_err_d     = 1'b0;
                resp_rdata_d   = '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables are gated by reset so nothing reaches memory while rst is low.
    assign mem_read_en   = rd_en & rst;
    assign mem_write_en  = wr_en & rst;
    assign mem_read_addr = addr_aligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, hand-written timing sequences, random ops vs. a reference model.
module tb_dmem_lsu;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

    dmem_lsu #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tb_mem  [0:15];
    logic [31:0] ref_mem [0:15];
    assign mem_read_data = tb_mem[mem_read_addr[5:2]];
    always @(posedge clk) if (mem_write_en) tb_mem[mem_write_addr[5:2]] <= mem_write_data;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] off,
                                logic [31:0] wdata, logic [31:0] er, logic ee);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = BASE + off;
        v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Reference: byte-lane arithmetic on a word array, applying alignment rules directly.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int sz, off, nbits, idx;
        logic [31:0] mask, word, v;
        sz = size; off = addr[1:0]; idx = addr[5:2]; err = 1'b0; rdata = 0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if (sz == 3 || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)) begin
            err = 1'b1;
            return;
        end
`else
        if (sz == 3) sz = 2;
`endif
        if (sz == 1) off = off - (off % 2);
        if (sz == 2) off = 0;
        nbits = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
        mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 1);
        word  = ref_mem[idx];
        if (we) begin
            ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        end else begin
            v = (word >> (8 * off)) & mask;
            if (sgn && nbits < 32 && v[nbits-1]) v = v | ~mask;
            rdata = v;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the response and one idle cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic en_seen);
        int cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        #1;
        cnt = 0;
        while (!req_ready && cnt < 5) begin @(posedge clk); #1; cnt++; end
        en_seen = mem_read_en | mem_write_en;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 4) begin @(posedge clk); #1; cnt++; end
        check("resp_valid arrives", {31'd0, resp_valid}, 32'd1);
        rdata = resp_rdata; err = resp_err;
        @(posedge clk); #1;
        check("resp_valid one pulse", {31'd0, resp_valid}, 32'd0);
    endtask

    logic [31:0] got_rd, exp_rd;
    logic        got_err, exp_err, en_seen;

    initial begin
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = BASE; req_wdata = 0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 0;
        tb_mem[0] = 32'h8899_AABB;
        #1;
        check("rst mem_read_en", {31'd0, mem_read_en}, 32'd0);
        check("rst mem_write_en", {31'd0, mem_write_en}, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", {31'd0, resp_err}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table, memory starts as word0=8899AABB, word1=0
        tbl.push_back(mk(0, 2'b00, 1, 1, 0, 32'hFFFF_FFAA, 0));
        tbl.push_back(mk(0, 2'b00, 0, 1, 0, 32'h0000_00AA, 0));
        tbl.push_back(mk(0, 2'b01, 1, 2, 0, 32'hFFFF_8899, 0));
        tbl.push_back(mk(0, 2'b01, 0, 2, 0, 32'h0000_8899, 0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 0, 32'hFFFF_FFBB, 0));
        tbl.push_back(mk(0, 2'b00, 0, 3, 0, 32'h0000_0088, 0));
        tbl.push_back(mk(1, 2'b00, 0, 3, 32'h12, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 0, 0, 32'h1299_AABB, 0));
        tbl.push_back(mk(1, 2'b10, 0, 4, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 4, 0, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(1, 2'b01, 0, 6, 32'h1234_ABCD, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 4, 0, 32'hABCD_BEEF, 0));
        tbl.push_back(mk(0, 2'b01, 1, 6, 0, 32'hFFFF_ABCD, 0));
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        tbl.push_back(mk(0, 2'b10, 0, 2, 0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b01, 1, 3, 0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 2'b01, 0, 5, 32'hFFFF, 32'h0, 1));
        tbl.push_back(mk(0, 2'b10, 0, 4, 0, 32'hABCD_BEEF, 0));
`else
        tbl.push_back(mk(0, 2'b10, 0, 2, 0, 32'h1299_AABB, 0));
        tbl.push_back(mk(0, 2'b01, 1, 3, 0, 32'h0000_1299, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 0, 32'h1299_AABB, 0));
        tbl.push_back(mk(1, 2'b01, 0, 5, 32'hFFFF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 4, 0, 32'hABCD_FFFF, 0));
`endif
        tbl.push_back(mk(1, 2'b00, 0, 4, 32'h77, 0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 4, 0, 32'h0000_0077, 0));

        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, got_rd, got_err, en_seen);
            check($sformatf("vec%0d rdata", i), got_rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d err", i), {31'd0, got_err}, {31'd0, tbl[i].exp_err});
            if (tbl[i].exp_err) check($sformatf("vec%0d no mem enable", i), {31'd0, en_seen}, 32'd0);
        end

        // Sub-word store timing: read in T, write in T+1 with ready low, response in T+2
        tb_mem[0] = 32'h8899_AABB;
        req_valid = 1; req_we = 1; req_size = 2'b00; req_signed = 0; req_addr = BASE + 3; req_wdata = 32'h12;
        #1;
        check("sb T read_en", {31'd0, mem_read_en}, 32'd1);
        check("sb T write_en", {31'd0, mem_write_en}, 32'd0);
        @(posedge clk); #1;
        req_valid = 0;
        check("sb T+1 ready", {31'd0, req_ready}, 32'd0);
        check("sb T+1 write_en", {31'd0, mem_write_en}, 32'd1);
        check("sb T+1 write_data", mem_write_data, 32'h1299_AABB);
        check("sb T+1 write_addr", mem_write_addr, BASE);
        check("sb T+1 resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("sb T+2 resp_valid", {31'd0, resp_valid}, 32'd1);
        check("sb T+2 mem", tb_mem[0], 32'h1299_AABB);
        @(posedge clk); #1;

        // Halfword store with a load presented the next cycle: the load stalls and sees the new data
        tb_mem[0] = 32'h8899_AABB;
        req_valid = 1; req_we = 1; req_size = 2'b01; req_addr = BASE; req_wdata = 32'hCAFE;
        @(posedge clk); #1;
        req_we = 0; req_size = 2'b10;
        #1;
        check("sh stall ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("sh resp_valid", {31'd0, resp_valid}, 32'd1);
        check("lw after sh ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        check("lw after sh valid", {31'd0, resp_valid}, 32'd1);
        check("lw after sh rdata", resp_rdata, 32'h8899_CAFE);
        @(posedge clk); #1;

        // Word store then load back-to-back
        req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = BASE + 4; req_wdata = 32'hDEAD_BEEF;
        #1;
        check("sw T write_en", {31'd0, mem_write_en}, 32'd1);
        @(posedge clk); #1;
        req_we = 0;
        #1;
        check("sw T+1 write_en", {31'd0, mem_write_en}, 32'd0);
        check("sw T+1 resp_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        check("lw after sw valid", {31'd0, resp_valid}, 32'd1);
        check("lw after sw rdata", resp_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset during the WRITE cycle of a byte store abandons the write
        req_valid = 1; req_we = 1; req_size = 2'b00; req_addr = BASE; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 0;
        #1;
        check("rstW write_en", {31'd0, mem_write_en}, 32'd0);
        check("rstW resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("rstW ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("rstW resp_valid after", {31'd0, resp_valid}, 32'd0);
        check("rstW write_en after", {31'd0, mem_write_en}, 32'd0);
        check("rstW mem unchanged", tb_mem[0], 32'h8899_CAFE);

        // Random operations against the reference model
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        for (int n = 0; n < 300; n++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            r_we = 1'($urandom_range(0, 1)); r_sgn = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = BASE + $urandom_range(0, 63); r_wdata = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wdata, exp_rd, exp_err);
            do_req(r_we, r_size, r_sgn, r_addr, r_wdata, got_rd, got_err, en_seen);
            check($sformatf("rnd%0d rdata a=%h sz=%0d we=%0d", n, r_addr, r_size, r_we), got_rd, exp_rd);
            check($sformatf("rnd%0d err", n), {31'd0, got_err}, {31'd0, exp_err});
        end
        for (int i = 0; i < 16; i++) check($sformatf("final mem%0d", i), tb_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
